dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, 1 = port 0 always wins, 0 = round-robin.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 pN_req  input  1  port N (N=0,1) access request, held until granted.
REQ-005 pN_addr / pN_wdata  input  32 / 32  byte address / store data, right-aligned.
REQ-006 pN_is_load  input  3  000 none, 001 LB, 010 LH, 011 LW, 101 LBU, 110 LHU.
REQ-007 pN_is_store  input  2  00 none, 01 SB, 10 SH, 11 SW.
REQ-008 pN_gnt  output  1  request accepted this cycle.
REQ-009 pN_rsp_valid / pN_rsp_err / pN_rd_data  output  1 / 1 / 32  completion, error flag, load data.
REQ-010 m_addr / m_wdata / m_is_load / m_is_store  output  32 / 32 / 3 / 2  to data memory, same encodings.
REQ-011 m_rd_data  input  32  data memory read result, valid one cycle after the load access.

Function
REQ-012 Arbitration SHALL be combinational: at most one pN_gnt per cycle; a requesting port with no competitor is granted the same cycle.
REQ-013 With both requesting, FIXED_PRIO=0: grant goes to the port not granted most recently (last_win register, reset to 1, so port 0 wins first); FIXED_PRIO=1: port 0.
REQ-014 Granted request SHALL drive m_* in the same cycle; with no grant, m_is_load=000, m_is_store=00, m_addr/m_wdata=0.
REQ-015 Misaligned request (LH/LHU/SH at addr[1:0]=11; LW/SW at addr[1:0]!=00) or both is_load and is_store nonzero SHALL be granted but not forwarded (m_* idle), and answered with rsp_err=1.
REQ-016 Request with is_load=000 and is_store=00 SHALL be granted, not forwarded, and answered with rsp_valid=1, rsp_err=0, rd_data=0.
REQ-017 Every grant SHALL produce exactly one pN_rsp_valid pulse on the granting port exactly one cycle later; loads return m_rd_data, stores and errors return rd_data=0.
REQ-018 Response tracking: registers rsp_port, rsp_pend, rsp_err; pN_rd_data SHALL be 0 whenever pN_rsp_valid=0.
REQ-019 Back-to-back grants SHALL be sustained (throughput one access per cycle); a response and a new grant on the same port in one cycle is legal.
REQ-020 Store-after-load same address in consecutive cycles: load response SHALL reflect pre-store data.
REQ-021 pN_req dropped without grant SHALL leave no state; last_win updates only on grant.
REQ-022 Requests with unused is_load codes (100, 111) SHALL be treated as errors per REQ-015.

Reset
REQ-023 On rst_n=0, immediately: rsp_pend=0, rsp_err=0, rsp_port=0, last_win=1; all pN_gnt, pN_rsp_valid, pN_rsp_err = 0; pN_rd_data = 0.
REQ-024 Reset mid-operation SHALL drop any pending response without emitting it; first grant after release follows REQ-013 from reset state.
REQ-025 No grants SHALL issue while rst_n=0.

Structure
REQ-026 Load/store encodings SHALL be typedef enums in shared package dmem_pkg, also used by the data memory and decoder.
REQ-027 Misalignment/illegal-op check SHALL be a combinational sub-module dmem_align_chk, instantiated once on the muxed request.

Verification
REQ-028 Only p0 LW addr 0x10 -> p0_gnt same cycle, m_is_load=011; next cycle p0_rsp_valid=1, p0_rd_data=m_rd_data.
REQ-029 Both request 4 cycles, FIXED_PRIO=0, p0 keeps requesting after each grant -> grants p0,p1,p0,p1; responses alternate ports one cycle behind.
REQ-030 p1 SH addr 0x03 -> p1_gnt=1, m_is_store=00, next cycle p1_rsp_valid=1, p1_rsp_err=1.
REQ-031 p0 SW 0x20 data 0xDEADBEEF then p1 LW 0x20 -> p1_rd_data=0xDEADBEEF.
REQ-032 Assert rst_n=0 in the cycle after a grant -> no rsp_valid emitted; after release, p0 wins the first contested cycle.
REQ-033 FIXED_PRIO=1, both requesting 3 cycles -> p0 granted every cycle, p1_gnt=0.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared data-memory access encodings and request payload, used by the arbiter,
// the data memory and the decoder.
package dmem_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [2:0] {
        LD_NONE = 3'b000,
        LD_LB   = 3'b001,
        LD_LH   = 3'b010,
        LD_LW   = 3'b011,
        LD_LBU  = 3'b101,
        LD_LHU  = 3'b110
    } load_op_e;

    typedef enum logic [1:0] {
        ST_NONE = 2'b00,
        ST_SB   = 2'b01,
        ST_SH   = 2'b10,
        ST_SW   = 2'b11
    } store_op_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        load_op_e          is_load;
        store_op_e         is_store;
    } dmem_req_t;

    // A request that neither loads nor stores completes without touching memory
    function automatic logic req_is_noop(input dmem_req_t r);
        return (r.is_load == LD_NONE) && (r.is_store == ST_NONE);
    endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// One requester port of the data-memory arbiter: request, grant and response.
interface dmem_arbiter_if;
    import dmem_pkg::*;

    logic              req;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    load_op_e          is_load;
    store_op_e         is_store;
    logic              gnt;
    logic              rsp_valid;
    logic              rsp_err;
    logic [DATA_W-1:0] rd_data;

    modport master (
        output req, addr, wdata, is_load, is_store,
        input  gnt, rsp_valid, rsp_err, rd_data
    );

    modport slave (
        input  req, addr, wdata, is_load, is_store,
        output gnt, rsp_valid, rsp_err, rd_data
    );
endinterface

// File: rtl/dmem_align_chk.sv
// Flags misaligned accesses, unused load codes and combined load+store requests.
module dmem_align_chk
    import dmem_pkg::*;
(
    input  logic [1:0] addr_lo,
    input  load_op_e   is_load,
    input  store_op_e  is_store,
    output logic       illegal_c
);

    always_comb begin
        illegal_c = (is_load != LD_NONE) && (is_store != ST_NONE);
        case (is_load)
            LD_NONE, LD_LB, LD_LBU: ;
            LD_LH, LD_LHU: if (addr_lo == 2'b11) illegal_c = 1'b1;
            LD_LW:         if (addr_lo != 2'b00) illegal_c = 1'b1;
            default:       illegal_c = 1'b1;
        endcase
        case (is_store)
            ST_SH:   if (addr_lo == 2'b11) illegal_c = 1'b1;
            ST_SW:   if (addr_lo != 2'b00) illegal_c = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter: combinational grant and forward, one-cycle
// registered response routed back to the granted port.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    dmem_arbiter_if.slave     p0,
    dmem_arbiter_if.slave     p1,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_wdata,
    output load_op_e          m_is_load,
    output store_op_e         m_is_store,
    input  logic [DATA_W-1:0] m_rd_data
);

    logic      last_win;
    logic      rsp_pend;
    logic      rsp_port;
    logic      rsp_err;
    logic      rsp_load;

    logic      sel_c;
    logic      gnt_c;
    logic      illegal_c;
    logic      fwd_c;
    dmem_req_t req_c;

    // Winner select: round-robin favours the port that did not win last time
    always_comb begin
        sel_c = 1'b0;
        if (p0.req && p1.req) begin
            sel_c = FIXED_PRIO ? 1'b0 : ~last_win;
        end else if (p1.req) begin
            sel_c = 1'b1;
        end
    end

    assign gnt_c  = rst_n & (p0.req | p1.req);
    assign p0.gnt = gnt_c & ~sel_c;
    assign p1.gnt = gnt_c &  sel_c;

    always_comb begin
        if (sel_c) begin
            req_c = {p1.addr, p1.wdata, p1.is_load, p1.is_store};
        end else begin
            req_c = {p0.addr, p0.wdata, p0.is_load, p0.is_store};
        end
    end

    dmem_align_chk u_align_chk (
        .addr_lo   (req_c.addr[1:0]),
        .is_load   (req_c.is_load),
        .is_store  (req_c.is_store),
        .illegal_c (illegal_c)
    );

    assign fwd_c = gnt_c & ~illegal_c & ~req_is_noop(req_c);

    // Memory side stays idle unless a legal, non-empty access is granted
    always_comb begin
        m_addr     = '0;
        m_wdata    = '0;
        m_is_load  = LD_NONE;
        m_is_store = ST_NONE;
        if (fwd_c) begin
            m_addr     = req_c.addr;
            m_wdata    = req_c.wdata;
            m_is_load  = req_c.is_load;
            m_is_store = req_c.is_store;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_pend <= 1'b0;
            rsp_port <= 1'b0;
            rsp_err  <= 1'b0;
            rsp_load <= 1'b0;
            last_win <= 1'b1;
        end else begin
            rsp_pend <= gnt_c;
            if (gnt_c) begin
                rsp_port <= sel_c;
                rsp_err  <= illegal_c;
                rsp_load <= fwd_c & (req_c.is_load != LD_NONE);
                last_win <= sel_c;
            end
        end
    end

    // Response fan-out; read data only passes through for a forwarded load
    assign p0.rsp_valid = rsp_pend & ~rsp_port;
    assign p1.rsp_valid = rsp_pend &  rsp_port;
    assign p0.rsp_err   = p0.rsp_valid & rsp_err;
    assign p1.rsp_err   = p1.rsp_valid & rsp_err;
    assign p0.rd_data   = (p0.rsp_valid & rsp_load) ? m_rd_data : '0;
    assign p1.rd_data   = (p1.rsp_valid & rsp_load) ? m_rd_data : '0;

endmodule
